// File: rtl/niosii_pio_in_capture.sv
// Avalon-MM input PIO: synchronises an external bus into clk, exposes it as a
// readable DATA register, and latches selected edges into a bit-clearable
// edge-capture register that can raise a maskable interrupt.
module niosii_pio_in_capture #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    EDGE_TYPE  = 0,
    parameter int                    IRQ_TYPE   = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_MASK = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] sync1_reg;
    logic [DATA_WIDTH-1:0] sync2_reg;
    logic [DATA_WIDTH-1:0] sync3_reg;
    logic [DATA_WIDTH-1:0] edge_capture_reg;
    logic [DATA_WIDTH-1:0] edge_capture_next;
    logic [DATA_WIDTH-1:0] irq_mask_reg;
    logic [DATA_WIDTH-1:0] irq_mask_next;
    logic [31:0]           readdata_reg;
    logic [31:0]           readdata_next;
    logic [DATA_WIDTH-1:0] edge_bit;
    logic                  wr_en;
    logic                  capture_clear_en;

    assign wr_en            = chipselect & ~write_n;
    assign capture_clear_en = wr_en && (address == 2'd3);

    // Upper write-data bits have no register behind them when the port is narrow.
    generate
        if (DATA_WIDTH < 32) begin : g_narrow
            logic unused_writedata;
            assign unused_writedata = &{1'b0, writedata[31:DATA_WIDTH]};
        end
    endgenerate

    // Per-bit edge detection on the two oldest synchroniser stages, and the
    // capture update where a new edge beats a simultaneous clear.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi = gi + 1) begin : g_bit
            if (EDGE_TYPE == 0) begin : g_rise
                assign edge_bit[gi] = sync2_reg[gi] & ~sync3_reg[gi];
            end else if (EDGE_TYPE == 1) begin : g_fall
                assign edge_bit[gi] = ~sync2_reg[gi] & sync3_reg[gi];
            end else begin : g_any
                assign edge_bit[gi] = sync2_reg[gi] ^ sync3_reg[gi];
            end
            assign edge_capture_next[gi] =
                (edge_capture_reg[gi] & ~(capture_clear_en & writedata[gi])) | edge_bit[gi];
        end
    endgenerate

    // Mask register takes the low write-data bits on a write to word 2.
    always_comb begin
        irq_mask_next = irq_mask_reg;
        if (wr_en && (address == 2'd2)) begin
            irq_mask_next = writedata[DATA_WIDTH-1:0];
        end
    end

    // Read mux runs every cycle; reads have no side effects.
    always_comb begin
        readdata_next = '0;
        case (address)
            2'd0:    readdata_next = 32'(sync2_reg);
            2'd1:    readdata_next = '0;
            2'd2:    readdata_next = 32'(irq_mask_reg);
            default: readdata_next = 32'(edge_capture_reg);
        endcase
    end

    // All state: synchroniser chain, capture, mask and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg        <= '0;
            sync2_reg        <= '0;
            sync3_reg        <= '0;
            edge_capture_reg <= '0;
            irq_mask_reg     <= RESET_MASK;
            readdata_reg     <= '0;
        end else begin
            sync1_reg        <= in_port;
            sync2_reg        <= sync1_reg;
            sync3_reg        <= sync2_reg;
            edge_capture_reg <= edge_capture_next;
            irq_mask_reg     <= irq_mask_next;
            readdata_reg     <= readdata_next;
        end
    end

    assign readdata = readdata_reg;

    // Interrupt is decoded from registered state only, so in_port cannot glitch it.
    generate
        if (IRQ_TYPE == 0) begin : g_irq_level
            assign irq = |(sync2_reg & irq_mask_reg);
        end else begin : g_irq_edge
            assign irq = |(edge_capture_reg & irq_mask_reg);
        end
    endgenerate

endmodule

// File: tb/tb_niosii_pio_in_capture.sv
// Bench for the input PIO: three instances on one shared bus (rising/edge-irq,
// any-edge/edge-irq, 12-bit falling/level-irq with non-zero reset mask).
module tb_niosii_pio_in_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_port;
    logic [31:0] rd_0, rd_1, rd_2;
    logic        irq_0, irq_1, irq_2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    niosii_pio_in_capture #(
        .DATA_WIDTH(32), .EDGE_TYPE(0), .IRQ_TYPE(1), .RESET_MASK(32'h0)
    ) u_e0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_0), .irq(irq_0)
    );

    niosii_pio_in_capture #(
        .DATA_WIDTH(32), .EDGE_TYPE(2), .IRQ_TYPE(1), .RESET_MASK(32'h0)
    ) u_e2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_1), .irq(irq_1)
    );

    niosii_pio_in_capture #(
        .DATA_WIDTH(12), .EDGE_TYPE(1), .IRQ_TYPE(0), .RESET_MASK(12'h100)
    ) u_lv (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port[11:0]),
        .readdata(rd_2), .irq(irq_2)
    );

    // ---------------- behavioural model ----------------
    // smp[0] is the newest in_port sample; the CPU-visible value is the sample
    // two edges old, and edges are judged between that and the one before it.
    logic [31:0] smp   [3];
    logic [31:0] m_cap [3];
    logic [31:0] m_mask[3];
    logic [31:0] m_rd  [3];

    function automatic int edge_type(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 1;
    endfunction

    function automatic int irq_type(input int i);
        return (i == 2) ? 0 : 1;
    endfunction

    function automatic logic [31:0] wmask(input int i);
        return (i == 2) ? 32'h0000_0FFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] reset_mask(input int i);
        return (i == 2) ? 32'h0000_0100 : 32'h0;
    endfunction

    function automatic logic [31:0] edges(input int et, input logic [31:0] now, input logic [31:0] old);
        case (et)
            0:       return now & ~old;
            1:       return ~now & old;
            default: return now ^ old;
        endcase
    endfunction

    function automatic logic [31:0] visible(input int i);
        return smp[1] & wmask(i);
    endfunction

    function automatic logic [31:0] read_value(input int i, input logic [1:0] a);
        case (a)
            2'd0:    return visible(i);
            2'd1:    return 32'h0;
            2'd2:    return m_mask[i];
            default: return m_cap[i];
        endcase
    endfunction

    function automatic logic irq_expect(input int i);
        if (irq_type(i) == 0) return |(visible(i) & m_mask[i]);
        return |(m_cap[i] & m_mask[i]);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                smp[i]    <= 32'h0;
                m_cap[i]  <= 32'h0;
                m_mask[i] <= reset_mask(i);
                m_rd[i]   <= 32'h0;
            end
        end else begin
            smp[0] <= in_port;
            smp[1] <= smp[0];
            smp[2] <= smp[1];
            for (int i = 0; i < 3; i++) begin
                m_rd[i] <= read_value(i, address);
                if (chipselect && !write_n && address == 2'd2)
                    m_mask[i] <= writedata & wmask(i);
                m_cap[i] <= ((m_cap[i] & ~((chipselect && !write_n && address == 2'd3) ? writedata : 32'h0))
                             | edges(edge_type(i), smp[1] & wmask(i), smp[2] & wmask(i))) & wmask(i);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        $display("[%0t] check %s value=%h want=%h", $time, name, got, exp);
        check(name, got, exp);
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("rd_e0",  rd_0, m_rd[0]);
        check("rd_e2",  rd_1, m_rd[1]);
        check("rd_lv",  rd_2, m_rd[2]);
        check("irq_e0", {31'h0, irq_0}, {31'h0, irq_expect(0)});
        check("irq_e2", {31'h0, irq_1}, {31'h0, irq_expect(1)});
        check("irq_lv", {31'h0, irq_2}, {31'h0, irq_expect(2)});
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("[%0t] write addr=%0d data=%h", $time, a, d);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 32'hA5A5_0000;
        tick(2);
        reset_n = 1'b1;

        // Reset values and DATA latency.
        tick(3);
        lit("data_e0", rd_0, 32'hA5A5_0000);
        lit("data_lv", rd_2, 32'h0000_0000);
        address = 2'd1;
        tick(1);
        lit("dir_e0", rd_0, 32'h0);
        address = 2'd2;
        tick(1);
        lit("mask_e0", rd_0, 32'h0);
        lit("mask_lv", rd_2, 32'h0000_0100);

        // Rising edge on bit0 with edge irq.
        in_port = 32'h0;
        tick(3);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'h0000_0001);
        in_port = 32'h0000_0001;
        tick(2);
        lit("irq_e0_k1", {31'h0, irq_0}, 32'h0);
        tick(1);
        lit("irq_e0_k2", {31'h0, irq_0}, 32'h1);
        bus_write(2'd3, 32'h0000_0001);
        lit("irq_e0_clr", {31'h0, irq_0}, 32'h0);

        // Any-edge capture on bit4, masked then unmasked.
        bus_write(2'd2, 32'h0);
        address = 2'd3;
        in_port = 32'h0000_0011;
        tick(4);
        in_port = 32'h0000_0001;
        tick(5);
        lit("cap_e2", rd_1, 32'h0000_0010);
        lit("cap_e0", rd_0, 32'h0000_0010);
        lit("irq_e2_masked", {31'h0, irq_1}, 32'h0);
        bus_write(2'd2, 32'h0000_0010);
        lit("irq_e2_unmask", {31'h0, irq_1}, 32'h1);

        // Edge and clear of bit3 in the same cycle: set wins.
        in_port = 32'h0000_0019;
        tick(2);
        bus_write(2'd3, 32'h0000_0008);
        tick(1);
        lit("cap_e0_setwins", rd_0, 32'h0000_0018);

        // Level irq on bit8.
        bus_write(2'd2, 32'h0000_0100);
        in_port = 32'h0000_0119;
        tick(1);
        lit("irq_lv_k", {31'h0, irq_2}, 32'h0);
        tick(1);
        lit("irq_lv_k1", {31'h0, irq_2}, 32'h1);
        in_port = 32'h0000_0019;
        tick(1);
        lit("irq_lv_hold", {31'h0, irq_2}, 32'h1);
        tick(1);
        lit("irq_lv_low", {31'h0, irq_2}, 32'h0);

        // Fill capture, then asynchronous reset mid-cycle.
        in_port = 32'h0;
        tick(3);
        in_port = 32'hFFFF_FFFF;
        tick(3);
        address = 2'd3;
        tick(1);
        lit("cap_e0_full", rd_0, 32'hFFFF_FFFF);
        lit("irq_e0_full", {31'h0, irq_0}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        lit("rst_rd_e0", rd_0, 32'h0);
        lit("rst_rd_e2", rd_1, 32'h0);
        lit("rst_irq_e0", {31'h0, irq_0}, 32'h0);
        lit("rst_irq_e2", {31'h0, irq_1}, 32'h0);
        in_port = 32'h0000_0001;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        lit("post_rst_cap0", rd_0, 32'h0);
        tick(1);
        lit("post_rst_cap1", rd_0, 32'h0000_0001);
        address = 2'd2;
        tick(2);
        lit("post_rst_mask_lv", rd_2, 32'h0000_0100);
        lit("post_rst_mask_e0", rd_0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
